// File: rtl/aprx_add_sched_if.sv
// Requester and response channels of the shared approximate-adder scheduler.
// The slave modport is the scheduler's view; master is the client side.
interface aprx_add_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_mode;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_mode;
    logic [15:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_mode, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_mode, rsp_data
    );
endinterface

// File: rtl/aprx_add_sched.sv
// Round-robin scheduler sharing one approximate FP adder among NUM_REQ requesters.
// One operation in flight: grant, wait ADD_LAT cycles, sample, return with id.
module aprx_add_sched #(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    aprx_add_sched_if.slave bus,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    output logic [31:0]     add_mode,
    input  logic [15:0]     add_c16,
    input  logic [7:0]      add_c8,
    output logic            busy
);
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, id_q, grant_id, rr_ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic               grant_found;
    logic               accept;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        a_q, b_q, sel_a, sel_b;
    logic               mode_q, sel_mode;
    logic [15:0]        data_q;
    logic               rsp_valid_q;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[ID_W'(idx)]) begin
                grant[ID_W'(idx)] = 1'b1;
                grant_id          = ID_W'(idx);
                grant_found       = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = bus.req_a[32*i +: 32];
                sel_b    = bus.req_b[32*i +: 32];
                sel_mode = bus.req_mode[i];
            end
        end
    end

    assign accept      = (state_q == IDLE) && grant_found;
    assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = WAIT;
            WAIT:    if (cnt_q == '0)    state_d = RESP;
            RESP:    if (bus.rsp_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Operand capture, latency counter and result sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q      <= sel_a;
                    b_q      <= sel_b;
                    mode_q   <= sel_mode;
                    id_q     <= grant_id;
                    rr_ptr_q <= rr_ptr_next;
                    cnt_q    <= CNT_W'(ADD_LAT - 1);
                end
                WAIT: if (cnt_q == '0) begin
                    data_q      <= mode_q ? {8'h00, add_c8} : add_c16;
                    rsp_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs; operands stay on add_* until the next accept.
    always_comb begin
        bus.req_ready = (state_q == IDLE) ? grant : '0;
        busy          = (state_q != IDLE);
        add_a         = a_q;
        add_b         = b_q;
        add_mode      = {31'b0, mode_q};
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_id    = id_q;
        bus.rsp_mode  = mode_q;
        bus.rsp_data  = data_q;
    end
endmodule

// File: tb/tb_aprx_add_sched.sv
// Directed bench for aprx_add_sched: ADD_LAT=1 and ADD_LAT=3 instances, with a
// response scoreboard per instance and cycle-level checks in the stimulus thread.
module tb_aprx_add_sched;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aprx_add_sched_if #(.NUM_REQ(4), .ID_W(2)) bus1 ();
    aprx_add_sched_if #(.NUM_REQ(4), .ID_W(2)) bus3 ();

    logic [31:0] add_a1, add_b1, add_mode1, add_a3, add_b3, add_mode3;
    logic [15:0] c16_1, c16_3;
    logic [7:0]  c8_1, c8_3;
    logic        busy1, busy3;

    aprx_add_sched #(.NUM_REQ(4), .ADD_LAT(1), .ID_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .add_a(add_a1), .add_b(add_b1), .add_mode(add_mode1),
        .add_c16(c16_1), .add_c8(c8_1), .busy(busy1)
    );

    aprx_add_sched #(.NUM_REQ(4), .ADD_LAT(3), .ID_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .add_a(add_a3), .add_b(add_b3), .add_mode(add_mode3),
        .add_c16(c16_3), .add_c8(c8_3), .busy(busy3)
    );

    typedef struct {
        logic [1:0]  id;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [31:0] op_a [4] = '{32'h420f0000, 32'h420f1000, 32'h420f2000, 32'h420f3000};
    logic [31:0] op_b [4] = '{32'h41a40000, 32'h41a40100, 32'h41a40200, 32'h41a40300};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitors: compare whenever a response handshake is about to happen.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.rsp_valid && bus1.rsp_ready) begin
            if (q1.size() == 0) begin
                check("lat1 unexpected response", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("lat1 rsp_id", bus1.rsp_id, e.id);
                check("lat1 rsp_mode", bus1.rsp_mode, e.mode);
                check("lat1 rsp_data", bus1.rsp_data, e.data);
                check("lat1 add_a", add_a1, e.a);
                check("lat1 add_b", add_b1, e.b);
                check("lat1 add_mode", add_mode1, {31'b0, e.mode});
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (bus3.rsp_valid && bus3.rsp_ready) begin
            if (q3.size() == 0) begin
                check("lat3 unexpected response", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                check("lat3 rsp_id", bus3.rsp_id, e.id);
                check("lat3 rsp_mode", bus3.rsp_mode, e.mode);
                check("lat3 rsp_data", bus3.rsp_data, e.data);
                check("lat3 add_a", add_a3, e.a);
                check("lat3 add_b", add_b3, e.b);
            end
        end
    end

    // One full ADD_LAT=1 operation with rsp_ready high; requester g must be the winner.
    task automatic op1(input logic [1:0] g, input logic [15:0] data);
        #1;
        check("lat1 grant onehot", bus1.req_ready, 4'b0001 << g);
        check("lat1 idle busy", busy1, 1'b0);
        q1.push_back('{id: g, mode: bus1.req_mode[g], a: op_a[g], b: op_b[g], data: data});
        tick();
        check("lat1 wait req_ready", bus1.req_ready, 4'b0000);
        check("lat1 wait busy", busy1, 1'b1);
        check("lat1 wait rsp_valid", bus1.rsp_valid, 1'b0);
        check("lat1 add_a after accept", add_a1, op_a[g]);
        tick();
        check("lat1 rsp_valid", bus1.rsp_valid, 1'b1);
        check("lat1 resp req_ready", bus1.req_ready, 4'b0000);
        tick();
    endtask

    initial begin
        bus1.req_valid = '0; bus1.req_mode = '0; bus1.rsp_ready = 1'b1;
        bus3.req_valid = '0; bus3.req_mode = '0; bus3.rsp_ready = 1'b1;
        bus1.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
        bus1.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
        bus3.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
        bus3.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
        c16_1 = 16'h4221; c8_1 = 8'h41;
        c16_3 = 16'h4221; c8_3 = 8'h41;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy1, 1'b0);
        check("reset add_a", add_a1, 32'h0);
        check("reset add_mode", add_mode1, 32'h0);
        check("reset rsp_valid", bus1.rsp_valid, 1'b0);
        check("reset rsp_data", bus1.rsp_data, 16'h0);
        check("reset req_ready", bus1.req_ready, 4'b0000);
        rst_n = 1'b1;
        tick();

        // Single request, mode 0
        bus1.req_valid = 4'b0001;
        op1(2'd0, 16'h4221);
        bus1.req_valid = 4'b0000;
        tick();
        check("idle after op busy", busy1, 1'b0);

        // Restart arbitration at requester 0, then all four contend
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
        bus1.req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) op1(2'(n % 4), 16'h4221);
        bus1.req_valid = 4'b0000;

        // Mode 1 response is zero-extended 8-bit result
        bus1.req_mode  = 4'b0100;
        bus1.req_valid = 4'b0100;
        op1(2'd2, 16'h0041);
        bus1.req_valid = 4'b0000;
        bus1.req_mode  = 4'b0000;

        // Backpressure: response held, no grants while RESP
        bus1.rsp_ready = 1'b0;
        bus1.req_valid = 4'b1111;
        #1;
        check("bp grant", bus1.req_ready, 4'b1000);
        q1.push_back('{id: 2'd3, mode: 1'b0, a: op_a[3], b: op_b[3], data: 16'h4221});
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp rsp_valid held", bus1.rsp_valid, 1'b1);
            check("bp rsp_id stable", bus1.rsp_id, 2'd3);
            check("bp rsp_data stable", bus1.rsp_data, 16'h4221);
            check("bp req_ready blocked", bus1.req_ready, 4'b0000);
            tick();
        end
        bus1.rsp_ready = 1'b1;
        #1;
        check("bp pre-handshake req_ready", bus1.req_ready, 4'b0000);
        tick();
        check("bp resume req_ready", bus1.req_ready, 4'b0001);
        op1(2'd0, 16'h4221);
        bus1.req_valid = 4'b0000;

        // Reset during WAIT discards the operation; pointer returns to 0
        bus1.req_valid = 4'b0010;
        #1;
        check("rst grant req1", bus1.req_ready, 4'b0010);
        tick();
        bus1.req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", busy1, 1'b0);
        check("mid rst rsp_valid", bus1.rsp_valid, 1'b0);
        check("mid rst add_a", add_a1, 32'h0);
        check("mid rst add_b", add_b1, 32'h0);
        check("mid rst rsp_id", bus1.rsp_id, 2'd0);
        check("mid rst req_ready", bus1.req_ready, 4'b0000);
        rst_n = 1'b1;
        tick();
        bus1.req_valid = 4'b1001;
        #1;
        check("post rst grant req0", bus1.req_ready, 4'b0001);
        op1(2'd0, 16'h4221);
        bus1.req_valid = 4'b0000;
        tick();
        check("no stale rsp", bus1.rsp_valid, 1'b0);

        // ADD_LAT=3: operands stable, sample only at the third edge
        bus3.req_valid = 4'b0010;
        #1;
        check("lat3 grant", bus3.req_ready, 4'b0010);
        q3.push_back('{id: 2'd1, mode: 1'b0, a: op_a[1], b: op_b[1], data: 16'h4221});
        tick();
        bus3.req_valid = 4'b0000;
        c16_3 = 16'hdead;
        check("lat3 add_a T+0", add_a3, op_a[1]);
        check("lat3 rsp_valid T+0", bus3.rsp_valid, 1'b0);
        tick();
        c16_3 = 16'hbeef;
        check("lat3 add_a T+1", add_a3, op_a[1]);
        check("lat3 rsp_valid T+1", bus3.rsp_valid, 1'b0);
        tick();
        c16_3 = 16'h4221;
        check("lat3 add_a T+2", add_a3, op_a[1]);
        check("lat3 rsp_valid T+2", bus3.rsp_valid, 1'b0);
        tick();
        c16_3 = 16'h1111;
        check("lat3 rsp_valid T+3", bus3.rsp_valid, 1'b1);
        check("lat3 add_a T+3", add_a3, op_a[1]);
        tick();
        tick();
        check("lat3 idle busy", busy3, 1'b0);

        check("lat1 scoreboard drained", q1.size(), 32'd0);
        check("lat3 scoreboard drained", q3.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
